// File: rtl/pio_arb_pkg.sv
// Shared types and helpers for the PIO arbiters: requester id width,
// return-pipe tag and the wrap-around round-robin search.
package pio_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } ret_pipe_t;

    // Returns {found, index}: first set bit of req[n-1:0] at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr,
                                              input int                 n);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !res[ID_W] && req[idx]) res = {1'b1, idx[ID_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: one-hot grant plus encoded index.
module rr_grant
    import pio_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [MAX_REQ-1:0] req_ext;
    logic [ID_W:0]      pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, ptr, N);
        any            = pick[ID_W];
        idx            = pick[ID_W-1:0];
        gnt            = '0;
        for (int i = 0; i < N; i++) gnt[i] = any && (idx == i[ID_W-1:0]);
    end

endmodule

// File: rtl/pio_read_arbiter.sv
// Shares one read-only PIO slave (1-cycle registered read) between NUM_REQ
// Avalon-MM read masters with round-robin arbitration and a bounded lock.
module pio_read_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         slv_address,
    input  logic [DATA_W-1:0]         slv_readdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d, locked_q, locked_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    ret_pipe_t          pipe_q, pipe_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [NUM_REQ-1:0] rr_gnt, gnt;
    logic [ID_W-1:0]    rr_idx, gnt_idx;
    logic               rr_any, gnt_any, hold, owner_rd, gnt_lock;
    logic [ADDR_W-1:0]  gnt_addr;

    rr_grant #(.N(NUM_REQ)) u_rr (
        .req (req_read),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        owner_rd = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (owner_q == i[ID_W-1:0]) owner_rd = req_read[i];
        // Locked owner keeps the slave until it has used up MAX_LOCK grants.
        hold    = reset_n && owner_vld_q && locked_q && owner_rd &&
                  (lock_cnt_q < CNT_W'(MAX_LOCK));
        gnt_idx = hold ? owner_q : rr_idx;
        gnt_any = reset_n && (hold || rr_any);

        gnt      = '0;
        gnt_addr = '0;
        gnt_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = gnt_any && (gnt_idx == i[ID_W-1:0]);
            if (gnt_idx == i[ID_W-1:0]) begin
                gnt_addr = req_address[i*ADDR_W +: ADDR_W];
                gnt_lock = req_lock[i];
            end
        end
    end

    assign req_waitrequest   = ~gnt;
    assign slv_address       = gnt_any ? gnt_addr : addr_q;
    assign req_readdata      = rdata_q;
    assign req_readdatavalid = rvalid_q;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        locked_d    = locked_q;
        lock_cnt_d  = lock_cnt_q;
        addr_d      = addr_q;
        pipe_d      = '{valid: gnt_any, id: gnt_idx};
        rdata_d     = rdata_q;
        rvalid_d    = '0;
        if (gnt_any) begin
            rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            owner_d     = gnt_idx;
            owner_vld_d = 1'b1;
            locked_d    = gnt_lock;
            lock_cnt_d  = hold ? lock_cnt_q + 1'b1 : CNT_W'(1);
            addr_d      = gnt_addr;
        end
        // Slave data for a read accepted last edge is on slv_readdata now.
        if (pipe_q.valid) begin
            rdata_d = slv_readdata;
            for (int i = 0; i < NUM_REQ; i++) rvalid_d[i] = (pipe_q.id == i[ID_W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            lock_cnt_q  <= '0;
            addr_q      <= '0;
            pipe_q      <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            locked_q    <= locked_d;
            lock_cnt_q  <= lock_cnt_d;
            addr_q      <= addr_d;
            pipe_q      <= pipe_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

endmodule
